muldiv_unit: RTL

Multi-cycle unsigned multiply/divide unit between the read and write ports of `registerbank`. It captures the two operands read from the bank (`rdDataA`, `rdDataB`) on a start request and iterates for 32 cycles. It then drives the bank's write port (`write`, `wrAddr`, `wrData`) for exactly one cycle to retire the result into the destination register. The design has one outstanding operation at a time, exposed through a `busy` / `done` handshake.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned multiply/divide unit that retires its
// result into a register bank through a one-cycle write port.
//
// Ports:
//   clk, resetN          clock and asynchronous active-low reset
//   start, op, dstAddr   request, operation select, destination register
//   opA, opB             operands (bank read data), latched at accept
//   busy, done           operation in flight / one-cycle completion pulse
//   result               last retired result, held until the next writeback
//   write, wrAddr,
//   wrData               bank write port, active for one cycle per operation
//
// Timing: accept at edge k, iterate at edges k+1..k+32, select the result in
// the WB state and present it on the registered outputs during k+33..k+34.
// The unit is already back in IDLE during that output cycle, so a held start
// is accepted again at edge k+34 (one operation every 34 cycles).
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    dstAddr,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             write,
  output logic [AW-1:0]    wrAddr,
  output logic [WIDTH-1:0] wrData
);

  localparam int unsigned CW      = $clog2(WIDTH);
  localparam int unsigned AccW    = 2 * WIDTH;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [AW-1:0]      dst_q, dst_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Multiply: {high partial, multiplier}. Divide: low word is dividend/quotient.
  logic [AccW-1:0]    acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               write_q, write_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]     mul_sum;
  logic [AccW-1:0]    mul_next;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH:0]     div_rem_next;
  logic [WIDTH-1:0]   div_quo_next;
  logic [WIDTH-1:0]   sel_result;

  // One shift-add step (LSB first) and one restoring-divide step (MSB first).
  always_comb begin
    mul_sum      = {1'b0, acc_q[AccW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial    = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_ge       = (div_trial >= {1'b0, b_q});
    div_rem_next = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
    div_quo_next = {acc_q[WIDTH-2:0], div_ge};
  end

  // Divide by zero needs no special case: every trial subtract succeeds,
  // giving an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    unique case (op_q)
      2'b00:   sel_result = acc_q[WIDTH-1:0];
      2'b01:   sel_result = acc_q[AccW-1:WIDTH];
      2'b10:   sel_result = acc_q[WIDTH-1:0];
      default: sel_result = rem_q[WIDTH-1:0];
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dst_d   = dst_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op;
          dst_d   = dstAddr;
          a_d     = opA;
          b_d     = opB;
          rem_d   = '0;
          acc_d   = {WIDTH'(0), (op[1] ? opA : opB)};
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[1]) begin
          acc_d = {acc_q[AccW-1:WIDTH], div_quo_next};
          rem_d = div_rem_next;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == LastIter) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered handshake and write-port outputs; the WB state loads them.
  always_comb begin
    busy_d    = (state_d != S_IDLE) || (state_q == S_WB);
    done_d    = (state_q == S_WB);
    write_d   = (state_q == S_WB) && (dst_q != '0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    result_d  = result_q;
    if (state_q == S_WB) begin
      wr_addr_d = dst_q;
      wr_data_d = sel_result;
      result_d  = sel_result;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      write_q   <= write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign write  = write_q;
  assign wrAddr = wr_addr_q;
  assign wrData = wr_data_q;
  assign result = result_q;

endmodule
